// File: rtl/closest_hit_select.sv
// closest_hit_select: keeps the nearest valid hit among a ray's candidates and emits it on three AXIS streams
module closest_hit_select #(
    parameter int              SIZE  = 32,
    parameter int              IDX_W = 8,
    parameter logic [SIZE-1:0] T_MIN = 32'h3a83126f,
    parameter logic [SIZE-1:0] T_MAX = 32'h7f7fffff
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [SIZE-1:0]     s_axis_tdata_t,
    input  logic [6*SIZE-1:0]   s_axis_tdata_obj,
    input  logic                s_axis_is_cylinder,
    input  logic [6*SIZE-1:0]   s_axis_tdata_ray,
    input  logic                s_axis_hit,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [SIZE-1:0]     t_axis_tdata,
    output logic                t_axis_hit,
    output logic                t_axis_tvalid,
    input  logic                t_axis_tready,
    output logic [6*SIZE-1:0]   obj_axis_tdata,
    output logic                obj_axis_is_cylinder,
    output logic [IDX_W-1:0]    obj_axis_index,
    output logic                obj_axis_tvalid,
    input  logic                obj_axis_tready,
    output logic [6*SIZE-1:0]   ray_axis_tdata,
    output logic                ray_axis_tvalid,
    input  logic                ray_axis_tready
);
    typedef enum logic {ACCUM, EMIT} state_t;
    state_t state, state_next;
    logic              best_valid, best_cyl, first, accept, q, take, pending;
    logic [SIZE-1:0]   best_t;
    logic [6*SIZE-1:0] best_obj, ray_q;
    logic [IDX_W-1:0]  best_idx, idx;
    // positive finite floats order like unsigned integers
    assign q = s_axis_hit && !s_axis_tdata_t[SIZE-1] && s_axis_tdata_t[SIZE-2 -: 8] != 8'hff
               && s_axis_tdata_t > T_MIN;
    assign take = q && (!best_valid || s_axis_tdata_t < best_t);
    assign s_axis_tready = state == ACCUM;
    assign accept = s_axis_tvalid && s_axis_tready;
    assign pending = (t_axis_tvalid && !t_axis_tready) || (obj_axis_tvalid && !obj_axis_tready)
                     || (ray_axis_tvalid && !ray_axis_tready);
    always_comb begin
        state_next = state;
        state_next = state == ACCUM ? (accept && s_axis_tlast ? EMIT : ACCUM) : (pending ? EMIT : ACCUM);
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state                <= ACCUM;
            best_valid           <= 1'b0;
            best_cyl             <= 1'b0;
            best_t               <= '0;
            best_obj             <= '0;
            best_idx             <= '0;
            ray_q                <= '0;
            idx                  <= '0;
            first                <= 1'b1;
            t_axis_tdata         <= '0;
            t_axis_hit           <= 1'b0;
            t_axis_tvalid        <= 1'b0;
            obj_axis_tdata       <= '0;
            obj_axis_is_cylinder <= 1'b0;
            obj_axis_index       <= '0;
            obj_axis_tvalid      <= 1'b0;
            ray_axis_tdata       <= '0;
            ray_axis_tvalid      <= 1'b0;
        end else begin
            state <= state_next;
            if (t_axis_tvalid && t_axis_tready) t_axis_tvalid <= 1'b0;
            if (obj_axis_tvalid && obj_axis_tready) obj_axis_tvalid <= 1'b0;
            if (ray_axis_tvalid && ray_axis_tready) ray_axis_tvalid <= 1'b0;
            if (accept) begin
                idx        <= s_axis_tlast ? '0 : idx + 1'b1;
                first      <= s_axis_tlast;
                best_valid <= !s_axis_tlast && (best_valid || take);
                if (first) ray_q <= s_axis_tdata_ray;
                if (take) begin
                    best_t   <= s_axis_tdata_t;
                    best_obj <= s_axis_tdata_obj;
                    best_cyl <= s_axis_is_cylinder;
                    best_idx <= idx;
                end
                // the final beat competes directly with the running best
                if (s_axis_tlast) begin
                    t_axis_tdata         <= take ? s_axis_tdata_t : best_valid ? best_t : T_MAX;
                    t_axis_hit           <= take || best_valid;
                    obj_axis_tdata       <= take ? s_axis_tdata_obj : best_valid ? best_obj : '0;
                    obj_axis_is_cylinder <= take ? s_axis_is_cylinder : best_valid && best_cyl;
                    obj_axis_index       <= take ? idx : best_valid ? best_idx : '0;
                    ray_axis_tdata       <= first ? s_axis_tdata_ray : ray_q;
                    t_axis_tvalid        <= 1'b1;
                    obj_axis_tvalid      <= 1'b1;
                    ray_axis_tvalid      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_closest_hit_select.sv
// tb_closest_hit_select: directed rays with a queue-based scoreboard per output stream
module tb_closest_hit_select;
    logic         aclk = 1'b0, areset = 1'b1;
    logic [31:0]  s_t = '0;
    logic [191:0] s_obj = '0, s_ray = '0;
    logic         s_cyl = 1'b0, s_hit = 1'b0, s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [31:0]  t_data;
    logic         t_hit, t_valid, t_r = 1'b1;
    logic [191:0] o_data, r_data;
    logic         o_cyl, o_valid, o_r = 1'b1, r_valid, r_r = 1'b1;
    logic [7:0]   o_idx;
    int           checks = 0, errs = 0, last_wait = 0;
    logic [32:0]  t_exp[$];
    logic [200:0] o_exp[$];
    logic [191:0] r_exp[$];

    localparam logic [31:0] TMAX = 32'h7f7fffff;

    closest_hit_select dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata_t(s_t), .s_axis_tdata_obj(s_obj), .s_axis_is_cylinder(s_cyl),
        .s_axis_tdata_ray(s_ray), .s_axis_hit(s_hit), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .t_axis_tdata(t_data), .t_axis_hit(t_hit), .t_axis_tvalid(t_valid), .t_axis_tready(t_r),
        .obj_axis_tdata(o_data), .obj_axis_is_cylinder(o_cyl), .obj_axis_index(o_idx),
        .obj_axis_tvalid(o_valid), .obj_axis_tready(o_r),
        .ray_axis_tdata(r_data), .ray_axis_tvalid(r_valid), .ray_axis_tready(r_r)
    );

    always #5 aclk = ~aclk;

    function automatic logic [191:0] pat(input logic [7:0] k);
        return {24{k}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [31:0] t, input logic hit, input logic cyl,
                              input logic [7:0] idx, input logic [191:0] obj, input logic [191:0] ray);
        t_exp.push_back({hit, t});
        o_exp.push_back({cyl, idx, obj});
        r_exp.push_back(ray);
    endtask

    // called at posedge+1; returns at posedge+1 just after the beat is accepted
    task automatic send(input logic [31:0] t, input logic [191:0] obj, input logic cyl,
                        input logic [191:0] ray, input logic hit, input logic last);
        int n = 0;
        s_t = t; s_obj = obj; s_cyl = cyl; s_ray = ray; s_hit = hit; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errs++;
            $display("FAIL send_timeout: tready never rose within %0d cycles", n);
        end
        last_wait = n;
        @(posedge aclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while ((!s_ready || t_valid || o_valid || r_valid) && n < 50) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errs++;
            $display("FAIL settle_timeout: outputs never drained");
        end
    endtask

    always @(negedge aclk) if (!areset) begin
        if (t_valid && t_r) begin
            if (t_exp.size() == 0) begin checks++; errs++; $display("FAIL t_unexpected: got %h", t_data); end
            else chk("t_stream", {223'd0, t_hit, t_data}, {223'd0, t_exp.pop_front()});
        end
        if (o_valid && o_r) begin
            if (o_exp.size() == 0) begin checks++; errs++; $display("FAIL obj_unexpected: got %h", o_data); end
            else chk("obj_stream", {55'd0, o_cyl, o_idx, o_data}, {55'd0, o_exp.pop_front()});
        end
        if (r_valid && r_r) begin
            if (r_exp.size() == 0) begin checks++; errs++; $display("FAIL ray_unexpected: got %h", r_data); end
            else chk("ray_stream", {64'd0, r_data}, {64'd0, r_exp.pop_front()});
        end
    end

    initial begin
        #1;
        chk("rst_valids", {t_valid, o_valid, r_valid}, 3'b000);
        chk("rst_tready", s_ready, 1'b1);
        chk("rst_data", {t_data, o_data, r_data, o_idx, t_hit, o_cyl}, '0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        // 1: nearest of three, ray latched from first beat
        expect_out(32'h40000000, 1, 1, 8'd1, pat(8'h12), pat(8'hA1));
        send(32'h40a00000, pat(8'h11), 0, pat(8'hA1), 1, 0);
        send(32'h40000000, pat(8'h12), 1, pat(8'hA2), 1, 0);
        send(32'h40e00000, pat(8'h13), 0, pat(8'hA3), 1, 1);
        // 2: no hits -> miss
        expect_out(TMAX, 0, 0, 8'd0, '0, pat(8'hB1));
        send(32'h3f800000, pat(8'h21), 1, pat(8'hB1), 0, 0);
        send(32'h40000000, pat(8'h22), 1, pat(8'hB2), 0, 0);
        send(32'h40400000, pat(8'h23), 1, pat(8'hB3), 0, 1);
        // 3: negative, NaN, below T_MIN all rejected
        expect_out(32'h40400000, 1, 1, 8'd3, pat(8'h34), pat(8'hC1));
        send(32'hbf800000, pat(8'h31), 0, pat(8'hC1), 1, 0);
        send(32'h7fc00000, pat(8'h32), 0, pat(8'hC2), 1, 0);
        send(32'h3a03126f, pat(8'h33), 0, pat(8'hC3), 1, 0);
        send(32'h40400000, pat(8'h34), 1, pat(8'hC4), 1, 1);
        // -0, +Inf and exactly T_MIN are rejected too
        expect_out(TMAX, 0, 0, 8'd0, '0, pat(8'hC5));
        send(32'h80000000, pat(8'h35), 1, pat(8'hC5), 1, 0);
        send(32'h7f800000, pat(8'h36), 1, pat(8'hC6), 1, 0);
        send(32'h3a83126f, pat(8'h37), 1, pat(8'hC7), 1, 1);
        // 4: tie keeps earlier, then back-to-back single-object ray
        expect_out(32'h40000000, 1, 0, 8'd0, pat(8'h41), pat(8'hD1));
        send(32'h40000000, pat(8'h41), 0, pat(8'hD1), 1, 0);
        send(32'h40000000, pat(8'h42), 1, pat(8'hD2), 1, 1);
        expect_out(32'h3f800000, 1, 1, 8'd0, pat(8'h43), pat(8'hD3));
        send(32'h3f800000, pat(8'h43), 1, pat(8'hD3), 1, 1);
        chk("b2b_idle_cycles", last_wait, 1);
        // 5: independent backpressure per stream
        settle();
        t_r = 1'b0; r_r = 1'b0; o_r = 1'b1;
        expect_out(32'h40800000, 1, 0, 8'd0, pat(8'h51), pat(8'hE1));
        send(32'h40800000, pat(8'h51), 0, pat(8'hE1), 1, 1);
        chk("bp_all_valid", {t_valid, o_valid, r_valid, s_ready}, 4'b1110);
        for (int c = 0; c < 7; c++) begin
            if (c == 2) r_r = 1'b1;
            if (c == 5) t_r = 1'b1;
            @(posedge aclk); #1;
            chk($sformatf("bp_c%0d", c), {t_valid, o_valid, r_valid, s_ready},
                {c < 5, 1'b0, c < 2, c >= 5});
            if (t_valid) chk("bp_t_stable", {t_hit, t_data}, {1'b1, 32'h40800000});
            if (r_valid) chk("bp_ray_stable", r_data, pat(8'hE1));
        end
        // 6: reset during EMIT discards the ray
        t_r = 1'b0; o_r = 1'b0; r_r = 1'b0;
        send(32'h3f800000, pat(8'h61), 0, pat(8'hF0), 1, 1);
        areset = 1'b1; #1;
        chk("rst_emit_valids", {t_valid, o_valid, r_valid, s_ready}, 4'b0001);
        @(posedge aclk); #1 areset = 1'b0;
        t_r = 1'b1; o_r = 1'b1; r_r = 1'b1;
        // reset mid-ray: the earlier closer beat must not leak into the next ray
        send(32'h3f800000, pat(8'h62), 1, pat(8'hF9), 1, 0);
        areset = 1'b1; #1;
        chk("rst_mid_valids", {t_valid, o_valid, r_valid, s_ready}, 4'b0001);
        @(posedge aclk); #1 areset = 1'b0;
        expect_out(32'h40a00000, 1, 0, 8'd0, pat(8'h63), pat(8'hF1));
        send(32'h40a00000, pat(8'h63), 0, pat(8'hF1), 1, 0);
        send(32'h40e00000, pat(8'h64), 1, pat(8'hF2), 1, 1);
        settle();
        repeat (2) @(posedge aclk);
        chk("drain", t_exp.size() + o_exp.size() + r_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
